// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the boot-image loader.
//   - loader_state_t : FSM state encoding
//   - PL_SYNC_BYTE   : default frame start marker
//   - PL_MAX_WORDS   : default largest accepted word count
//   - field widths   : byte, word, address and word-count widths
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 7;

  localparam logic [BYTE_W-1:0] PL_SYNC_BYTE = 8'hA5;
  localparam int                PL_MAX_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// word_packer: assembles little-endian 32-bit words from a byte stream and
// keeps the running XOR checksum of every data byte in the frame.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_clear        : start of a new frame, clears index, word and checksum
//   i_byte_en      : i_byte is a data byte accepted this cycle
//   i_byte         : data byte
//   o_idx_last     : the next accepted byte completes the current word
//   o_word_next    : word value including i_byte (valid when completing)
//   o_csum         : XOR of all data bytes accepted since i_clear
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_idx_last,
  output logic [WORD_W-1:0] o_word_next,
  output logic [BYTE_W-1:0] o_csum
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_word;
  logic [BYTE_W-1:0] r_csum;

  // Bytes enter at the top and shift down, so after four bytes the first
  // one received sits in bits [7:0].
  assign o_word_next = {i_byte, r_word[WORD_W-1:BYTE_W]};
  assign o_idx_last  = (r_idx == 2'd3);
  assign o_csum      = r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
      r_csum <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
      r_csum <= '0;
    end else if (i_byte_en) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= o_word_next;
      r_csum <= r_csum ^ i_byte;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte link, writes it
// word by word into instruction memory and holds the CPU in reset until a
// frame with a matching checksum has been loaded.
//   clk, rst           : clock, asynchronous active-low reset
//   in_data/in_valid   : byte stream from the host link
//   in_ready           : a byte transfers when in_valid and in_ready are high
//   imem_we/addr/wdata : instruction memory write port (one cycle per word)
//   cpu_hold           : 1 keeps the CPU in reset
//   done / err         : last frame loaded OK / rejected
//   words_loaded       : words written in the current or last frame
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for sync byte, other bytes dropped
// COUNT    | expecting word count N
// DATA     | collecting the 4 bytes of a word
// WRITE    | one-cycle write strobe for the assembled word
// CHECK    | expecting checksum byte
// DONE     | frame good, CPU released, sync byte restarts a load
// ERROR    | frame rejected, CPU held, sync byte restarts a load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE = PL_SYNC_BYTE,
  parameter int                MAX_WORDS = PL_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam logic [BYTE_W-1:0] MAX_N = BYTE_W'(MAX_WORDS);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic              w_sync;
  logic              w_start;
  logic              w_byte_en;
  logic              w_idx_last;
  logic [WORD_W-1:0] w_word_next;
  logic [BYTE_W-1:0] w_csum;
  logic              w_count_bad;
  logic              w_last_word;

  // Ready is gated by reset so a host never sees a handshake while the
  // loader is being held in reset.
  assign w_ready     = (r_state != ST_WRITE);
  assign in_ready    = rst & w_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_sync      = w_accept & (in_data == SYNC_BYTE);
  assign w_count_bad = (in_data == '0) || (in_data > MAX_N);
  assign w_last_word = ((r_words + CNT_W'(1)) == r_n);

  word_packer u_word_packer (
    .clk         (clk),
    .rst_n       (rst),
    .i_clear     (w_start),
    .i_byte_en   (w_byte_en),
    .i_byte      (in_data),
    .o_idx_last  (w_idx_last),
    .o_word_next (w_word_next),
    .o_csum      (w_csum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_byte_en = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_sync) begin
          w_next  = ST_COUNT;
          w_start = 1'b1;
        end
      end
      ST_COUNT: begin
        if (w_accept) begin
          w_next = w_count_bad ? ST_ERROR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_byte_en = 1'b1;
          if (w_idx_last) begin
            w_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        w_next = w_last_word ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        if (w_accept) begin
          w_next = (in_data == w_csum) ? ST_DONE : ST_ERROR;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address and data are captured when the word completes so they are
  // already stable during WRITE and simply hold afterwards. N is capped at
  // MAX_WORDS (<= 64), so the address never needs more than 6 index bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n     <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_start) begin
        r_words <= '0;
      end
      if ((r_state == ST_COUNT) && w_accept && !w_count_bad) begin
        r_n <= in_data[CNT_W-1:0];
      end
      if ((r_state == ST_DATA) && w_accept && w_idx_last) begin
        r_addr  <= {r_words[5:0], 2'b00};
        r_wdata <= w_word_next;
      end
      if (r_state == ST_WRITE) begin
        r_words <= r_words + CNT_W'(1);
      end
    end
  end

  assign imem_we      = (r_state == ST_WRITE);
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign done         = (r_state == ST_DONE);
  assign err          = (r_state == ST_ERROR);
  assign cpu_hold     = (r_state != ST_DONE);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  int checks = 0;
  int failures = 0;

  logic [7:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int          wr_cnt = 0;

  prog_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr[wr_cnt[7:0]] = imem_addr;
      wr_data[wr_cnt[7:0]] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      t = t >> 8;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cpu_hold !== 1'b1)      begin failures++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    checks++; if (imem_we !== 1'b0)       begin failures++; $display("FAIL rst_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 8'h00)    begin failures++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0)   begin failures++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_done_err got=%b%b exp=00", done, err); end
    checks++; if (words_loaded !== 7'd0)  begin failures++; $display("FAIL rst_words got=%0d exp=0", words_loaded); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)      begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    int base;
    base = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++; if (imem_we !== 1'b1)          begin failures++; $display("FAIL single_we_latency got=%b exp=1", imem_we); end
    checks++; if (imem_addr !== 8'h00)       begin failures++; $display("FAIL single_addr got=%h exp=00", imem_addr); end
    checks++; if (imem_wdata !== 32'h13)     begin failures++; $display("FAIL single_wdata got=%h exp=00000013", imem_wdata); end
    send_byte(8'h13, 0);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL single_status got done=%b hold=%b err=%b exp 1 0 0", done, cpu_hold, err);
    end
    checks++; if (words_loaded !== 7'd1)     begin failures++; $display("FAIL single_words got=%0d exp=1", words_loaded); end
    checks++; if (wr_cnt - base !== 1)       begin failures++; $display("FAIL single_nwrites got=%0d exp=1", wr_cnt - base); end
  endtask

  // Words 0x00500093, 0x00100113: XOR of bytes 93,00,50,00,13,01,10,00 = C1.
  task automatic test_two_words(input logic [7:0] csum, input logic good);
    int base;
    base = wr_cnt;
    send_byte(8'hA5, 0);
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL restart_status got hold=%b done=%b err=%b exp 1 0 0", cpu_hold, done, err);
    end
    send_byte(8'h02, 0);
    send_word(32'h0050_0093, 0);
    send_word(32'h0010_0113, 0);
    send_byte(csum, 0);
    checks++; if (wr_cnt - base !== 2) begin failures++; $display("FAIL two_nwrites got=%0d exp=2", wr_cnt - base); end
    checks++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h0050_0093) begin
      failures++; $display("FAIL two_w0 got=%h/%h exp=00/00500093", wr_addr[base], wr_data[base]);
    end
    checks++; if (wr_addr[base+1] !== 8'h04 || wr_data[base+1] !== 32'h0010_0113) begin
      failures++; $display("FAIL two_w1 got=%h/%h exp=04/00100113", wr_addr[base+1], wr_data[base+1]);
    end
    checks++; if (words_loaded !== 7'd2) begin failures++; $display("FAIL two_words got=%0d exp=2", words_loaded); end
    checks++; if (done !== good || err !== !good || cpu_hold !== !good) begin
      failures++; $display("FAIL two_status got done=%b err=%b hold=%b exp %b %b %b", done, err, cpu_hold, good, !good, !good);
    end
  endtask

  task automatic test_bad_count(input logic [7:0] cnt);
    int base;
    base = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(cnt, 0);
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL badcnt_%h_status got err=%b done=%b hold=%b exp 1 0 1", cnt, err, done, cpu_hold);
    end
    checks++; if (wr_cnt !== base) begin failures++; $display("FAIL badcnt_%h_writes got=%0d exp=0", cnt, wr_cnt - base); end
  endtask

  task automatic test_max_frame();
    int base;
    int bad;
    logic [7:0]  cs;
    logic [31:0] w;
    base = wr_cnt;
    cs = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), ~8'(i), 8'h11, 8'(3 * i)};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w, 0);
    end
    send_byte(cs, 0);
    checks++; if (wr_cnt - base !== 64) begin failures++; $display("FAIL max_nwrites got=%0d exp=64", wr_cnt - base); end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), ~8'(i), 8'h11, 8'(3 * i)};
      if (wr_addr[base+i] !== 8'(4 * i) || wr_data[base+i] !== w) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL max_contents got=%0d bad words exp=0", bad); end
    checks++; if (wr_addr[base+63] !== 8'hFC) begin failures++; $display("FAIL max_last_addr got=%h exp=fc", wr_addr[base+63]); end
    checks++; if (words_loaded !== 7'd64 || done !== 1'b1) begin
      failures++; $display("FAIL max_status got words=%0d done=%b exp 64 1", words_loaded, done);
    end
  endtask

  task automatic test_stall();
    int base;
    pulse_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== 7'd0) begin
      failures++; $display("FAIL lead_bytes got hold=%b done=%b err=%b words=%0d exp 1 0 0 0", cpu_hold, done, err, words_loaded);
    end
    base = wr_cnt;
    send_byte(8'hA5, 2);
    send_byte(8'h02, 3);
    send_word(32'h0050_0093, 4);
    send_word(32'h0010_0113, 4);
    send_byte(8'hC1, 3);
    checks++; if (wr_cnt - base !== 2 || wr_data[base] !== 32'h0050_0093 || wr_data[base+1] !== 32'h0010_0113) begin
      failures++; $display("FAIL stall_wdata got n=%0d %h %h exp 2 00500093 00100113", wr_cnt - base, wr_data[base], wr_data[base+1]);
    end
    checks++; if (done !== 1'b1 || words_loaded !== 7'd2) begin
      failures++; $display("FAIL stall_status got done=%b words=%0d exp 1 2", done, words_loaded);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      failures++; $display("FAIL midrst_port got we=%b addr=%h wdata=%h exp 0 00 0", imem_we, imem_addr, imem_wdata);
    end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== 7'd0) begin
      failures++; $display("FAIL midrst_status got hold=%b done=%b err=%b words=%0d exp 1 0 0 0", cpu_hold, done, err, words_loaded);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt !== base) begin failures++; $display("FAIL midrst_nowrite got=%0d exp=0", wr_cnt - base); end
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'h13, 0);
    checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h13) begin
      failures++; $display("FAIL midrst_reload got n=%0d addr=%h data=%h exp 1 00 00000013", wr_cnt - base, wr_addr[base], wr_data[base]);
    end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL midrst_done got done=%b hold=%b exp 1 0", done, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_words(8'hC1, 1'b1);
    test_two_words(8'hC2, 1'b0);
    test_bad_count(8'h00);
    test_bad_count(8'h41);
    test_max_frame();
    test_stall();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
